qracc_compute_sequencer: RTL and testbench

- Sequences one layer's compute through the accelerator datapath: activation buffer internal read, then feature loader staging, then seq_acc MAC handshake, then output-scaler settle, then activation buffer internal write-back.
- Sits between qracc_controller, which programs it and starts it, and the datapath strobes (activation_buffer_int_*, feature_loader_*, qracc_mac_data_valid).
- Runs `num_ops` output vectors per start and reports completion with a single done pulse.

---
 rtl/qracc_pkg.sv | 38 +++
 rtl/qracc_strided_addr_gen.sv | 36 +++
 rtl/qracc_compute_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_qracc_compute_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared types and defaults for the QRAcc compute sequencer.
// Struct field widths track the sequencer's default parameter widths.
package qracc_pkg;

    localparam int QRACC_SEQ_ADDR_W          = 32;
    localparam int QRACC_SEQ_OPCNT_W         = 16;
    localparam int QRACC_SEQ_FETCH_W         = 8;
    localparam int QRACC_SEQ_SCALER_LATENCY  = 2;
    localparam int QRACC_SEQ_SETTLE_W        = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DRAIN    = 3'd2,
        MAC      = 3'd3,
        WAIT_OUT = 3'd4,
        SCALE    = 3'd5,
        WRITE    = 3'd6,
        DONE     = 3'd7
    } qracc_seq_state_e;

    typedef struct packed {
        logic [QRACC_SEQ_OPCNT_W-1:0] num_ops;
        logic [QRACC_SEQ_FETCH_W-1:0] fetches_per_op;
        logic [QRACC_SEQ_ADDR_W-1:0]  rd_base;
        logic [QRACC_SEQ_ADDR_W-1:0]  rd_stride;
        logic [QRACC_SEQ_ADDR_W-1:0]  wr_base;
        logic [QRACC_SEQ_ADDR_W-1:0]  wr_stride;
    } qracc_seq_cfg_t;

    // A fetch count of zero still performs one read per op.
    function automatic logic [QRACC_SEQ_FETCH_W-1:0] qracc_seq_eff_fetches(
        input logic [QRACC_SEQ_FETCH_W-1:0] f
    );
        return (f == '0) ? QRACC_SEQ_FETCH_W'(1) : f;
    endfunction

endpackage

// File: rtl/qracc_strided_addr_gen.sv
// Strided address pointer: load a base, then advance by a stride per step.
// Arithmetic wraps modulo 2^addrWidth.
module qracc_strided_addr_gen #(
    parameter int addrWidth = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [addrWidth-1:0] base_i,
    input  logic [addrWidth-1:0] stride_i,
    output logic [addrWidth-1:0] addr_o
);

    logic [addrWidth-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = base_i;
        end else if (step_i) begin
            addr_d = addr_q + stride_i;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/qracc_compute_sequencer.sv
// Per-layer compute sequencer: buffer read, feature-loader staging, MAC handshake,
// scaler settle and write-back, repeated num_ops times with a single done pulse.
module qracc_compute_sequencer
    import qracc_pkg::*;
#(
    parameter int addrWidth       = QRACC_SEQ_ADDR_W,
    parameter int opCountWidth    = QRACC_SEQ_OPCNT_W,
    parameter int fetchCountWidth = QRACC_SEQ_FETCH_W,
    parameter int scalerLatency   = QRACC_SEQ_SCALER_LATENCY
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [opCountWidth-1:0]    num_ops_i,
    input  logic [fetchCountWidth-1:0] fetches_per_op_i,
    input  logic [addrWidth-1:0]       rd_base_i,
    input  logic [addrWidth-1:0]       rd_stride_i,
    input  logic [addrWidth-1:0]       wr_base_i,
    input  logic [addrWidth-1:0]       wr_stride_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       buf_rd_en_o,
    output logic [addrWidth-1:0]       buf_rd_addr_o,
    output logic                       fl_wr_en_o,
    output logic [addrWidth-1:0]       fl_addr_o,
    output logic                       mac_valid_o,
    input  logic                       qracc_ready_i,
    input  logic                       qracc_valid_i,
    output logic                       buf_wr_en_o,
    output logic [addrWidth-1:0]       buf_wr_addr_o
);

    localparam int SETTLE_W = QRACC_SEQ_SETTLE_W;
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(scalerLatency);

    qracc_seq_state_e state_q, state_d;
    qracc_seq_cfg_t   cfg_d;

    logic [opCountWidth-1:0]    num_ops_q;
    logic [opCountWidth-1:0]    op_cnt_q, op_cnt_d;
    logic [fetchCountWidth-1:0] fetches_q;
    logic [fetchCountWidth-1:0] fetch_idx_q, fetch_idx_d;
    logic [fetchCountWidth-1:0] fl_idx_q;
    logic [addrWidth-1:0]       rd_stride_q;
    logic [addrWidth-1:0]       wr_stride_q;
    logic [SETTLE_W-1:0]        settle_q, settle_d;

    logic busy_q;
    logic done_q;
    logic rd_en_q;
    logic fl_wr_en_q;
    logic mac_valid_q;
    logic wr_en_q;

    logic start_ok;
    logic abort_ok;
    logic mac_accept;

    // Configuration as seen on the start cycle.
    always_comb begin
        cfg_d.num_ops        = QRACC_SEQ_OPCNT_W'(num_ops_i);
        cfg_d.fetches_per_op = qracc_seq_eff_fetches(QRACC_SEQ_FETCH_W'(fetches_per_op_i));
        cfg_d.rd_base        = QRACC_SEQ_ADDR_W'(rd_base_i);
        cfg_d.rd_stride      = QRACC_SEQ_ADDR_W'(rd_stride_i);
        cfg_d.wr_base        = QRACC_SEQ_ADDR_W'(wr_base_i);
        cfg_d.wr_stride      = QRACC_SEQ_ADDR_W'(wr_stride_i);
    end

    assign start_ok   = start_i && (state_q == IDLE);
    assign abort_ok   = abort_i && (state_q != IDLE);
    assign mac_accept = mac_valid_q && qracc_ready_i;

    always_comb begin
        state_d     = state_q;
        op_cnt_d    = op_cnt_q;
        fetch_idx_d = fetch_idx_q;
        settle_d    = settle_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_cnt_d    = '0;
                    fetch_idx_d = '0;
                    state_d     = (cfg_d.num_ops == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                fetch_idx_d = fetch_idx_q + 1'b1;
                if (fetch_idx_q == fetches_q - 1'b1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = MAC;
            MAC: begin
                if (mac_accept) begin
                    state_d = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (qracc_valid_i) begin
                    settle_d = SETTLE_INIT;
                    state_d  = SCALE;
                end
            end
            SCALE: begin
                // A load of 0 or 1 both give a single settle cycle.
                settle_d = (settle_q != '0) ? settle_q - 1'b1 : '0;
                if (settle_q <= SETTLE_W'(1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                op_cnt_d    = op_cnt_q + 1'b1;
                fetch_idx_d = '0;
                state_d     = (op_cnt_d == num_ops_q) ? DONE : FETCH;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_ok) begin
            state_d = IDLE;
        end
    end

    // Strobes are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            op_cnt_q    <= '0;
            fetch_idx_q <= '0;
            settle_q    <= '0;
            num_ops_q   <= '0;
            fetches_q   <= '0;
            rd_stride_q <= '0;
            wr_stride_q <= '0;
            fl_idx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            fl_wr_en_q  <= 1'b0;
            mac_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_cnt_q    <= op_cnt_d;
            fetch_idx_q <= fetch_idx_d;
            settle_q    <= settle_d;
            if (start_ok) begin
                num_ops_q   <= opCountWidth'(cfg_d.num_ops);
                fetches_q   <= fetchCountWidth'(cfg_d.fetches_per_op);
                rd_stride_q <= addrWidth'(cfg_d.rd_stride);
                wr_stride_q <= addrWidth'(cfg_d.wr_stride);
            end
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            rd_en_q     <= (state_d == FETCH);
            mac_valid_q <= (state_d == MAC);
            wr_en_q     <= (state_d == WRITE);
            // Feature loader sees buffer data one cycle after the read.
            fl_wr_en_q  <= rd_en_q && !abort_ok;
            if (rd_en_q) begin
                fl_idx_q <= fetch_idx_q;
            end
        end
    end

    qracc_strided_addr_gen #(
        .addrWidth (addrWidth)
    ) u_rd_addr (
        .clk      (clk),
        .nrst     (nrst),
        .load_i   (start_ok),
        .step_i   (rd_en_q),
        .base_i   (addrWidth'(cfg_d.rd_base)),
        .stride_i (rd_stride_q),
        .addr_o   (buf_rd_addr_o)
    );

    qracc_strided_addr_gen #(
        .addrWidth (addrWidth)
    ) u_wr_addr (
        .clk      (clk),
        .nrst     (nrst),
        .load_i   (start_ok),
        .step_i   (wr_en_q),
        .base_i   (addrWidth'(cfg_d.wr_base)),
        .stride_i (wr_stride_q),
        .addr_o   (buf_wr_addr_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign buf_rd_en_o = rd_en_q;
    assign fl_wr_en_o  = fl_wr_en_q;
    assign fl_addr_o   = addrWidth'(fl_idx_q);
    assign mac_valid_o = mac_valid_q;
    assign buf_wr_en_o = wr_en_q;

endmodule

// File: tb/tb_qracc_compute_sequencer.sv
// Directed bench for qracc_compute_sequencer with a seq_acc responder and
// address scoreboards fed at job start and drained as strobes appear.
module tb_qracc_compute_sequencer;

    localparam int AW = 32;
    localparam int OW = 16;
    localparam int FW = 8;
    localparam int SL = 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [OW-1:0] num_ops_i = '0;
    logic [FW-1:0] fetches_per_op_i = '0;
    logic [AW-1:0] rd_base_i = '0, rd_stride_i = '0, wr_base_i = '0, wr_stride_i = '0;
    logic          busy_o, done_o, buf_rd_en_o, fl_wr_en_o, mac_valid_o, buf_wr_en_o;
    logic [AW-1:0] buf_rd_addr_o, fl_addr_o, buf_wr_addr_o;
    logic          qracc_ready_i = 1'b0;
    logic          qracc_valid_i;
    logic          resp_valid = 1'b0;
    logic          spur_valid = 1'b0;

    assign qracc_valid_i = resp_valid | spur_valid;

    qracc_compute_sequencer #(
        .addrWidth(AW), .opCountWidth(OW), .fetchCountWidth(FW), .scalerLatency(SL)
    ) dut (
        .clk(clk), .nrst(nrst), .start_i(start_i), .abort_i(abort_i),
        .num_ops_i(num_ops_i), .fetches_per_op_i(fetches_per_op_i),
        .rd_base_i(rd_base_i), .rd_stride_i(rd_stride_i),
        .wr_base_i(wr_base_i), .wr_stride_i(wr_stride_i),
        .busy_o(busy_o), .done_o(done_o),
        .buf_rd_en_o(buf_rd_en_o), .buf_rd_addr_o(buf_rd_addr_o),
        .fl_wr_en_o(fl_wr_en_o), .fl_addr_o(fl_addr_o),
        .mac_valid_o(mac_valid_o), .qracc_ready_i(qracc_ready_i),
        .qracc_valid_i(qracc_valid_i),
        .buf_wr_en_o(buf_wr_en_o), .buf_wr_addr_o(buf_wr_addr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_base = 0;
    int ready_delay = 0;
    int valid_lat = 3;
    int mac_run = 0;
    int since_acc = -1;

    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] exp_fl[$];
    logic [AW-1:0] exp_wr[$];
    int            exp_mac[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain plus seq_acc model: ready after ready_delay MAC cycles,
    // valid pulse valid_lat cycles after acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (buf_rd_en_o) begin
                    check("rd_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) check("rd_addr", buf_rd_addr_o, exp_rd.pop_front());
                end
                if (fl_wr_en_o) begin
                    check("fl_expected", exp_fl.size() != 0, 1);
                    if (exp_fl.size() != 0) check("fl_addr", fl_addr_o, exp_fl.pop_front());
                end
                if (buf_wr_en_o) begin
                    check("wr_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) check("wr_addr", buf_wr_addr_o, exp_wr.pop_front());
                end
                if (done_o) done_cnt++;
                if (mac_valid_o) begin
                    mac_run++;
                end else if (mac_run != 0) begin
                    check("mac_expected", exp_mac.size() != 0, 1);
                    if (exp_mac.size() != 0) check("mac_len", mac_run, exp_mac.pop_front());
                    mac_run = 0;
                end
                if (since_acc >= 0) since_acc++;
                qracc_ready_i = mac_valid_o && (mac_run > ready_delay);
                if (qracc_ready_i) since_acc = 0;
                resp_valid = (since_acc == valid_lat);
            end else begin
                mac_run = 0;
                since_acc = -1;
                qracc_ready_i = 1'b0;
                resp_valid = 1'b0;
            end
        end
    end

    // Called on a negedge; returns on the negedge after the start cycle.
    task automatic start_job(input int n, input int f, input logic [AW-1:0] rb, input logic [AW-1:0] rs,
                             input logic [AW-1:0] wb, input logic [AW-1:0] ws, input int rdly, input int vl);
        int fe;
        logic [AW-1:0] ra, wa;
        fe = (f == 0) ? 1 : f;
        ra = rb;
        wa = wb;
        ready_delay = rdly;
        valid_lat = vl;
        for (int o = 0; o < n; o++) begin
            for (int k = 0; k < fe; k++) begin
                exp_rd.push_back(ra);
                exp_fl.push_back(AW'(k));
                ra = ra + rs;
            end
            exp_mac.push_back(rdly + 1);
            exp_wr.push_back(wa);
            wa = wa + ws;
        end
        num_ops_i = OW'(n);
        fetches_per_op_i = FW'(f);
        rd_base_i = rb; rd_stride_i = rs; wr_base_i = wb; wr_stride_i = ws;
        start_i = 1'b1;
        start_cyc = cyc;
        done_base = done_cnt;
        @(negedge clk);
        start_i = 1'b0;
        num_ops_i = OW'($urandom);
        fetches_per_op_i = FW'($urandom);
        rd_base_i = $urandom; rd_stride_i = $urandom;
        wr_base_i = $urandom; wr_stride_i = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!done_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done_o, 1);
        check({tag, "_latency"}, cyc - start_cyc, exp_lat);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done_o, 0);
        check({tag, "_busy_after"}, busy_o, 0);
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
        check({tag, "_fl_left"}, exp_fl.size(), 0);
        check({tag, "_wr_left"}, exp_wr.size(), 0);
        check({tag, "_mac_left"}, exp_mac.size(), 0);
    endtask

    function automatic int op_cycles(input int f, input int rdly, input int vl);
        int fe;
        fe = (f == 0) ? 1 : f;
        return fe + 1 + (rdly + 1) + vl + ((SL == 0) ? 1 : SL) + 1;
    endfunction

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_strobes", {buf_rd_en_o, fl_wr_en_o, mac_valid_o, buf_wr_en_o}, 4'b0);
        check("rst_rd_addr", buf_rd_addr_o, 0);
        check("rst_wr_addr", buf_wr_addr_o, 0);
        check("rst_fl_addr", fl_addr_o, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Basic two-op run, with a stray start mid-run
        start_job(2, 1, 32'h10, 32'h1, 32'h80, 32'h1, 0, 3);
        check("basic_busy_rise", busy_o, 1);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("basic", 1 + 2 * op_cycles(1, 0, 3));

        // Multi-fetch timing
        start_job(1, 3, 32'h20, 32'h4, 32'h100, 32'h8, 0, 2);
        check("mf_rd0_en", buf_rd_en_o, 1);
        check("mf_rd0_addr", buf_rd_addr_o, 32'h20);
        check("mf_fl0_en", fl_wr_en_o, 0);
        @(negedge clk);
        check("mf_rd1_addr", buf_rd_addr_o, 32'h24);
        check("mf_fl1_en", fl_wr_en_o, 1);
        check("mf_fl1_addr", fl_addr_o, 0);
        @(negedge clk);
        check("mf_rd2_addr", buf_rd_addr_o, 32'h28);
        check("mf_fl2_addr", fl_addr_o, 1);
        @(negedge clk);
        check("mf_drain_rd", buf_rd_en_o, 0);
        check("mf_drain_fl", {fl_wr_en_o, fl_addr_o}, {1'b1, 32'h2});
        check("mf_drain_mac", mac_valid_o, 0);
        @(negedge clk);
        check("mf_mac_rise", mac_valid_o, 1);
        check("mf_fl_off", fl_wr_en_o, 0);
        wait_done("multifetch", 1 + op_cycles(3, 0, 2));

        // Backpressure with spurious valid during MAC
        start_job(1, 2, 32'h40, 32'h1, 32'h200, 32'h1, 4, 2);
        n = 0;
        while (!mac_valid_o && n < 50) begin @(negedge clk); n++; end
        check("bp_mac_seen", mac_valid_o, 1);
        @(negedge clk);
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        check("bp_mac_held", mac_valid_o, 1);
        wait_done("backpressure", 1 + op_cycles(2, 4, 2));

        // Empty job
        start_job(0, 1, 32'h0, 32'h1, 32'h0, 32'h1, 0, 3);
        wait_done("empty", 1);

        // Abort in WAIT_OUT
        start_job(1, 1, 32'h300, 32'h1, 32'h400, 32'h1, 0, 6);
        n = 0;
        while (!mac_valid_o && n < 50) begin @(negedge clk); n++; end
        check("ab_mac_seen", mac_valid_o, 1);
        @(negedge clk);
        check("ab_in_wait", {busy_o, mac_valid_o}, 2'b10);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("ab_busy", busy_o, 0);
        check("ab_strobes", {done_o, buf_rd_en_o, fl_wr_en_o, mac_valid_o, buf_wr_en_o}, 5'b0);
        repeat (8) @(negedge clk);
        check("ab_no_done", done_cnt - done_base, 0);
        check("ab_no_wr", exp_wr.size(), 1);
        check("ab_rd_left", exp_rd.size(), 0);
        exp_wr.delete();
        start_job(1, 1, 32'h500, 32'h2, 32'h600, 32'h4, 0, 1);
        wait_done("post_abort", 1 + op_cycles(1, 0, 1));

        // Address wrap with F=0
        start_job(2, 0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1, 0, 2);
        wait_done("wrap", 1 + 2 * op_cycles(0, 0, 2));

        // Asynchronous reset mid-fetch
        start_job(1, 3, 32'h20, 32'h1, 32'h0, 32'h1, 0, 2);
        check("ar_fetching", buf_rd_en_o, 1);
        #2 nrst = 1'b0;
        #1;
        check("ar_busy", busy_o, 0);
        check("ar_strobes", {buf_rd_en_o, fl_wr_en_o, mac_valid_o, buf_wr_en_o, done_o}, 5'b0);
        check("ar_rd_addr", buf_rd_addr_o, 0);
        exp_rd.delete(); exp_fl.delete(); exp_wr.delete(); exp_mac.delete();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
